// File: rtl/dm_responder_if.sv
// CPU-side memory bus between a requester and the dm_responder data memory.
// Signal names follow the original port list so existing hookups carry over.
interface dm_responder_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    logic        busy;
    logic        ready;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, addr, wdata, byteen,
        input  busy, ready, rdata, err
    );

    modport slave (
        input  req, addr, wdata, byteen,
        output busy, ready, rdata, err
    );
endinterface

// File: rtl/dm_responder.sv
// Fixed-latency word-addressed data memory: accepts one request, waits LATENCY
// cycles, then performs a byte-lane write or a read and pulses ready for one cycle.
module dm_responder #(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter int unsigned LATENCY     = 2
) (
    input logic           clk,
    input logic           reset,
    dm_responder_if.slave bus
);
    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [29:0] idx_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;
    logic        err_q;
    logic        ready_q;
    logic        busy_q;

    logic [29:0]   op_idx;
    logic [31:0]   op_wdata;
    logic [3:0]    op_be;
    logic [31:0]   merged_d;
    logic [AW-1:0] mem_idx;
    logic          in_range;
    logic          enter_resp;
    logic          unused_addr;

    assign unused_addr = ^bus.addr[1:0];

    // With LATENCY=0 the access happens on the accepting edge, so it must use the live bus.
    always_comb begin
        if (state_q == IDLE) begin
            op_idx   = bus.addr[31:2];
            op_wdata = bus.wdata;
            op_be    = bus.byteen;
        end else begin
            op_idx   = idx_q;
            op_wdata = wdata_q;
            op_be    = be_q;
        end
        in_range = ({2'b00, op_idx} < 32'(DEPTH_WORDS));
        mem_idx  = in_range ? op_idx[AW-1:0] : '0;
        merged_d = mem_q[mem_idx];
        for (int unsigned i = 0; i < 4; i++) begin
            if (op_be[i]) merged_d[8*i +: 8] = op_wdata[8*i +: 8];
        end
        enter_resp = ((state_q == IDLE) && bus.req && (LATENCY == 0)) ||
                     ((state_q == WAIT) && (cnt_q == 4'd1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[AW'(i)] <= '0;
            end
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        idx_q   <= bus.addr[31:2];
                        wdata_q <= bus.wdata;
                        be_q    <= bus.byteen;
                        cnt_q   <= 4'(LATENCY);
                        state_q <= WAIT;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT: cnt_q <= cnt_q - 4'd1;
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            // Later assignments override the IDLE->WAIT step when no wait is needed.
            if (enter_resp) begin
                state_q <= RESP;
                busy_q  <= 1'b1;
                ready_q <= 1'b1;
                err_q   <= ~in_range;
                rdata_q <= in_range ? merged_d : '0;
                if (in_range && (op_be != 4'b0000)) mem_q[mem_idx] <= merged_d;
            end
        end
    end

    assign bus.busy  = busy_q;
    assign bus.ready = ready_q;
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed vector table, LATENCY=0 timing sequences,
// reset abort, and randomized traffic against a byte-lane memory model.
module tb_dm_responder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dm_responder_if bus2();
    dm_responder_if bus0();

    dm_responder #(.DEPTH_WORDS(3072), .LATENCY(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));
    dm_responder #(.DEPTH_WORDS(3072), .LATENCY(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));

    int checks = 0;
    int errors = 0;
    logic [31:0] mem_m [3072];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory behaviour from the lane rules: word index = addr/4, out of range -> err, rdata 0.
    function automatic void model(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                                  output logic [31:0] rd, output logic e);
        int unsigned idx;
        idx = a / 4;
        if (idx >= 3072) begin
            rd = '0;
            e  = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_m[idx][8*i +: 8] = wd[8*i +: 8];
            end
            rd = mem_m[idx];
            e  = 1'b0;
        end
    endfunction

    task automatic txn2(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] exp_rd, input logic exp_e, input bit noise);
        int k;
        bit seen;
        k = 0;
        while (bus2.busy && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        bus2.req = 1'b1; bus2.addr = a; bus2.wdata = wd; bus2.byteen = be;
        @(posedge clk); #1;
        bus2.req = 1'b0;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            if (bus2.ready) begin
                seen = 1'b1;
            end else begin
                if (noise) begin
                    bus2.req = 1'($urandom); bus2.addr = $urandom;
                    bus2.wdata = $urandom; bus2.byteen = 4'($urandom);
                end
                @(posedge clk); #1;
                k++;
            end
        end
        chk("resp_seen", 32'(seen), 32'd1);
        chk("latency", k, 2);
        chk("rdata", bus2.rdata, exp_rd);
        chk("err", 32'(bus2.err), 32'(exp_e));
        if (noise) bus2.req = 1'($urandom);
        @(posedge clk); #1;
        bus2.req = 1'b0;
        chk("ready_drop", 32'(bus2.ready), 32'd0);
        chk("busy_idle", 32'(bus2.busy), 32'd0);
        chk("rdata_hold", bus2.rdata, exp_rd);
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          any_ready;

        vecs[0]  = '{32'h10,       32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{32'h10,       32'h0,        4'b0000, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{32'h10,       32'h0000AA00, 4'b0010, 32'hDEADAAEF, 1'b0};
        vecs[3]  = '{32'h10,       32'h0,        4'b0000, 32'hDEADAAEF, 1'b0};
        vecs[4]  = '{32'h10,       32'h12340000, 4'b1100, 32'h1234AAEF, 1'b0};
        vecs[5]  = '{32'h10,       32'h0,        4'b0000, 32'h1234AAEF, 1'b0};
        vecs[6]  = '{32'h3000,     32'h0,        4'b0000, 32'h0,        1'b1};
        vecs[7]  = '{32'h3000,     32'hFFFFFFFF, 4'b1111, 32'h0,        1'b1};
        vecs[8]  = '{32'h0,        32'h0,        4'b0000, 32'h0,        1'b0};
        vecs[9]  = '{32'h2FFC,     32'h0,        4'b0000, 32'h0,        1'b0};
        vecs[10] = '{32'h2FFF,     32'hFF11FF22, 4'b1010, 32'hFF00FF00, 1'b0};
        vecs[11] = '{32'h2FFC,     32'h0,        4'b0000, 32'hFF00FF00, 1'b0};
        vecs[12] = '{32'hFFFFFFF0, 32'h0,        4'b0000, 32'h0,        1'b1};

        foreach (mem_m[i]) mem_m[i] = '0;
        bus2.req = 1'b0; bus2.addr = '0; bus2.wdata = '0; bus2.byteen = '0;
        bus0.req = 1'b0; bus0.addr = '0; bus0.wdata = '0; bus0.byteen = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready2", 32'(bus2.ready), 32'd0);
        chk("rst_busy2", 32'(bus2.busy), 32'd0);
        chk("rst_err2", 32'(bus2.err), 32'd0);
        chk("rst_rdata2", bus2.rdata, 32'd0);
        chk("rst_ready0", 32'(bus0.ready), 32'd0);
        chk("rst_busy0", 32'(bus0.busy), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            model(vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, e);
            txn2(vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].exp_rdata, vecs[i].exp_err, 1'b0);
        end

        // Reset wins over a simultaneous request.
        bus0.req = 1'b1; bus0.addr = 32'h40; bus0.wdata = 32'h55AA55AA; bus0.byteen = 4'b1111;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; bus0.req = 1'b0;
        chk("rst_vs_req_ready", 32'(bus0.ready), 32'd0);
        chk("rst_vs_req_busy", 32'(bus0.busy), 32'd0);
        foreach (mem_m[i]) mem_m[i] = '0;

        // LATENCY=0 with req held high: accept, respond, accept, ...
        bus0.req = 1'b1; bus0.addr = 32'h44; bus0.wdata = 32'h0BADF00D; bus0.byteen = 4'b1111;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            chk("held_busy", 32'(bus0.busy), 32'(k % 2));
            chk("held_ready", 32'(bus0.ready), 32'(k % 2));
            if (k == 1) begin
                chk("lat0_wr_rdata", bus0.rdata, 32'h0BADF00D);
                chk("lat0_wr_err", 32'(bus0.err), 32'd0);
            end
        end
        bus0.req = 1'b0;
        @(posedge clk); #1;
        bus0.req = 1'b1; bus0.addr = 32'h46; bus0.byteen = 4'b0000; bus0.wdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus0.req = 1'b0;
        chk("lat0_rd_ready", 32'(bus0.ready), 32'd1);
        chk("lat0_rd_rdata", bus0.rdata, 32'h0BADF00D);

        // Write with a reset landing during WAIT: aborted, memory cleared.
        model(32'h10, 32'h0, 4'b0000, rd, e);
        txn2(32'h10, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b0);
        bus2.req = 1'b1; bus2.addr = 32'h20; bus2.wdata = 32'hFFFFFFFF; bus2.byteen = 4'b1111;
        @(posedge clk); #1;
        bus2.req = 1'b0;
        chk("abort_busy", 32'(bus2.busy), 32'd1);
        model(32'h10, 32'hCAFEF00D, 4'b1111, rd, e);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        foreach (mem_m[i]) mem_m[i] = '0;
        chk("abort_ready", 32'(bus2.ready), 32'd0);
        chk("abort_busy_rst", 32'(bus2.busy), 32'd0);
        chk("abort_err", 32'(bus2.err), 32'd0);
        chk("abort_rdata", bus2.rdata, 32'd0);
        any_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (bus2.ready) any_ready = 1'b1;
        end
        chk("abort_no_ready", 32'(any_ready), 32'd0);
        txn2(32'h20, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b0);

        // Randomized traffic with bus noise while the transaction is in flight.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) != 0) a = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
            else a = 32'h2FF0 + 32'($urandom_range(0, 63));
            be = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
            wd = $urandom;
            model(a, wd, be, rd, e);
            txn2(a, wd, be, rd, e, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
